// File: rtl/quad_pkg.sv
// Shared decode constants and types for the quadrature decoder.
package quad_pkg;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_SAT     = 1;

    // Indexed by the current {A,B} state: forward order is 00->01->11->10->00.
    localparam logic [1:0] FWD_NEXT [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    localparam logic [1:0] REV_NEXT [4] = '{2'b10, 2'b00, 2'b11, 2'b01};

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } step_t;

    typedef enum logic {
        PRIMING,
        RUN
    } prime_state_t;

    function automatic step_t classify_step(input logic [1:0] prev, input logic [1:0] cur);
        if (cur == prev) begin
            return STEP_NONE;
        end else if (cur == FWD_NEXT[prev]) begin
            return STEP_FWD;
        end else if (cur == REV_NEXT[prev]) begin
            return STEP_REV;
        end
        return STEP_ILLEGAL;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Per-channel 2-FF synchroniser followed by a stability filter that only
// accepts a new level once it has been held for FILTER_CYCLES cycles.
module quad_input_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filtered
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            run      <= '0;
            filtered <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // run counts consecutive cycles of disagreement; any agreement restarts it
            if (sync2 != filtered) begin
                if (run == CW'(FILTER_CYCLES - 1)) begin
                    filtered <= sync2;
                    run      <= '0;
                end else begin
                    run <= run + 1'b1;
                end
            end else begin
                run <= '0;
            end
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B decode into a wrapping position count and
// a saturating per-window velocity sample on an Avalon-ST source.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int COUNT_WIDTH   = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int VEL_WIDTH     = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   sample,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] position,
    output logic                   direction,
    output logic [VEL_WIDTH-1:0]   ast_source_data,
    output logic                   ast_source_valid,
    output logic [1:0]             ast_source_error
);

    localparam int PRIME_CYCLES = FILTER_CYCLES + 2;
    localparam int PW           = $clog2(PRIME_CYCLES + 1);
    localparam logic [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
    localparam logic [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

    logic           filt_a;
    logic           filt_b;
    logic [1:0]     enc_state;
    logic [1:0]     prev_state;
    step_t          step;
    prime_state_t   prime_q;
    prime_state_t   prime_d;
    logic [PW-1:0]  prime_cnt_q;
    logic [PW-1:0]  prime_cnt_d;
    logic           primed;
    logic           step_fwd;
    logic           step_rev;
    logic           illegal_now;
    logic           sat_now;
    logic [VEL_WIDTH-1:0] acc_q;
    logic [VEL_WIDTH-1:0] acc_d;
    logic           sat_q;
    logic           illegal_q;

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (enc_a),
        .filtered (filt_a)
    );

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (enc_b),
        .filtered (filt_b)
    );

    // Priming lets the filters settle onto the real encoder level after reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prime_q     <= PRIMING;
            prime_cnt_q <= '0;
        end else begin
            prime_q     <= prime_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    always_comb begin
        prime_d     = prime_q;
        prime_cnt_d = prime_cnt_q;
        case (prime_q)
            PRIMING: begin
                if (prime_cnt_q == PW'(PRIME_CYCLES - 1)) begin
                    prime_d = RUN;
                end else begin
                    prime_cnt_d = prime_cnt_q + 1'b1;
                end
            end
            RUN:     prime_d = RUN;
            default: prime_d = PRIMING;
        endcase
    end

    always_comb begin
        enc_state   = {filt_a, filt_b};
        step        = classify_step(prev_state, enc_state);
        primed      = (prime_q == RUN);
        step_fwd    = primed && (step == STEP_FWD);
        step_rev    = primed && (step == STEP_REV);
        illegal_now = primed && (step == STEP_ILLEGAL);
    end

    always_comb begin
        acc_d   = acc_q;
        sat_now = 1'b0;
        if (step_fwd) begin
            if (acc_q == VEL_MAX) begin
                sat_now = 1'b1;
            end else begin
                acc_d = acc_q + 1'b1;
            end
        end else if (step_rev) begin
            if (acc_q == VEL_MIN) begin
                sat_now = 1'b1;
            end else begin
                acc_d = acc_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_state       <= '0;
            position         <= '0;
            direction        <= 1'b0;
            acc_q            <= '0;
            sat_q            <= 1'b0;
            illegal_q        <= 1'b0;
            ast_source_data  <= '0;
            ast_source_valid <= 1'b0;
            ast_source_error <= '0;
        end else begin
            prev_state <= enc_state;

            if (clear) begin
                position <= '0;
            end else if (step_fwd) begin
                position <= position + 1'b1;
            end else if (step_rev) begin
                position <= position - 1'b1;
            end

            if (step_fwd) begin
                direction <= 1'b1;
            end else if (step_rev) begin
                direction <= 1'b0;
            end

            // The strobe cycle's own step and flags belong to the closing window
            if (sample) begin
                ast_source_data                <= acc_d;
                ast_source_valid               <= 1'b1;
                ast_source_error[ERR_SAT]      <= sat_q | sat_now;
                ast_source_error[ERR_ILLEGAL]  <= illegal_q | illegal_now;
                acc_q                          <= '0;
                sat_q                          <= 1'b0;
                illegal_q                      <= 1'b0;
            end else begin
                ast_source_valid <= 1'b0;
                acc_q            <= acc_d;
                sat_q            <= sat_q | sat_now;
                illegal_q        <= illegal_q | illegal_now;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomised and directed bench for quadrature_decoder against a step-event
// model that treats the input path as a fixed 7-cycle delay.
module tb_quadrature_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enc_a;
    logic        enc_b;
    logic        sample;
    logic        clear;
    logic [15:0] position;
    logic        direction;
    logic [11:0] ast_source_data;
    logic        ast_source_valid;
    logic [1:0]  ast_source_error;

    quadrature_decoder #(
        .COUNT_WIDTH   (16),
        .FILTER_CYCLES (4),
        .VEL_WIDTH     (12)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enc_a            (enc_a),
        .enc_b            (enc_b),
        .sample           (sample),
        .clear            (clear),
        .position         (position),
        .direction        (direction),
        .ast_source_data  (ast_source_data),
        .ast_source_valid (ast_source_valid),
        .ast_source_error (ast_source_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int kind;
    } ev_t;

    localparam int LATENCY = 7;
    localparam int KIND_ILLEGAL = 2;

    ev_t        q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         chk_en = 1'b0;
    bit         rnd = 1'b0;
    int         idx = 0;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic [15:0] m_pos = '0;
    logic        m_dir = 1'b0;
    logic [11:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic [1:0]  m_err = '0;
    int          m_acc = 0;
    bit          m_sat = 1'b0;
    bit          m_ill = 1'b0;
    int          m_since = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: every accepted encoder change becomes a +1/-1/illegal event LATENCY edges later
    always @(posedge clk) begin
        automatic int  c;
        automatic int  d;
        automatic bit  il;
        automatic bit  s;
        automatic int  a;
        automatic ev_t ev;
        c  = cyc + 1;
        d  = 0;
        il = 1'b0;
        s  = 1'b0;
        cyc <= c;
        if (!reset_n) begin
            q.delete();
            m_pos   <= '0;
            m_dir   <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_err   <= '0;
            m_acc   <= 0;
            m_sat   <= 1'b0;
            m_ill   <= 1'b0;
            m_since <= 0;
        end else begin
            while (q.size() > 0 && q[0].due <= c) begin
                ev = q.pop_front();
                if (m_since + 1 >= LATENCY) begin
                    if (ev.kind == KIND_ILLEGAL) il = 1'b1;
                    else d += ev.kind;
                end
            end
            m_since <= m_since + 1;
            if (clear) m_pos <= '0;
            else       m_pos <= m_pos + 16'(d);
            if (d > 0) m_dir <= 1'b1;
            if (d < 0) m_dir <= 1'b0;
            a = m_acc + d;
            if (a > 2047)  begin a = 2047;  s = 1'b1; end
            if (a < -2048) begin a = -2048; s = 1'b1; end
            if (sample) begin
                m_data  <= 12'(a);
                m_valid <= 1'b1;
                m_err   <= {m_sat | s, m_ill | il};
                m_acc   <= 0;
                m_sat   <= 1'b0;
                m_ill   <= 1'b0;
            end else begin
                m_valid <= 1'b0;
                m_acc   <= a;
                m_sat   <= m_sat | s;
                m_ill   <= m_ill | il;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("position",  32'(position),         32'(m_pos));
            check("direction", 32'(direction),        32'(m_dir));
            check("data",      32'(ast_source_data),  32'(m_data));
            check("valid",     32'(ast_source_valid), 32'(m_valid));
            check("error",     32'(ast_source_error), 32'(m_err));
        end
    end

    task automatic tick(input bit s, input bit c);
        @(negedge clk);
        if (rnd) begin
            sample = ($urandom_range(0, 11) == 0);
            clear  = ($urandom_range(0, 39) == 0);
        end else begin
            sample = s;
            clear  = c;
        end
    endtask

    task automatic drive_to(input int new_idx, input int kind);
        ev_t ev;
        idx = new_idx & 3;
        enc_a = gray[idx][1];
        enc_b = gray[idx][0];
        ev.due  = cyc + LATENCY;
        ev.kind = kind;
        q.push_back(ev);
    endtask

    task automatic step(input int d, input int hold);
        tick(0, 0);
        drive_to(idx + d, d);
        repeat (hold - 1) tick(0, 0);
    endtask

    task automatic glitch(input bit on_a, input int len);
        tick(0, 0);
        if (on_a) enc_a = ~enc_a; else enc_b = ~enc_b;
        repeat (len) tick(0, 0);
        if (on_a) enc_a = ~enc_a; else enc_b = ~enc_b;
        repeat (5) tick(0, 0);
    endtask

    task automatic close_window();
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int r;
        reset_n = 1'b0;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        sample  = 1'b0;
        clear   = 1'b0;
        tick(0, 0);
        chk_en = 1'b1;
        repeat (2) tick(0, 0);
        check("reset_position", 32'(position),         32'h0);
        check("reset_valid",    32'(ast_source_valid), 32'h0);
        check("reset_error",    32'(ast_source_error), 32'h0);
        reset_n = 1'b1;
        repeat (10) tick(0, 0);

        // Eight forward steps; the second is an A edge used for latency
        step(1, 10);
        tick(0, 0);
        drive_to(idx + 1, 1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (position == 16'd2) begin
                lat = k;
                break;
            end
        end
        check("enc_a_latency", 32'(lat), 32'd7);
        repeat (6) step(1, 10);
        repeat (10) tick(0, 0);
        check("fwd_position",  32'(position),  32'd8);
        check("fwd_direction", 32'(direction), 32'd1);

        tick(0, 1);
        tick(0, 0);
        check("clear_position", 32'(position), 32'd0);
        repeat (3) step(-1, 10);
        repeat (10) tick(0, 0);
        check("rev_position",  32'(position),  32'hFFFD);
        check("rev_direction", 32'(direction), 32'd0);

        glitch(1'b1, 3);
        glitch(1'b0, 2);
        repeat (10) tick(0, 0);
        check("glitch_position", 32'(position), 32'hFFFD);
        close_window();
        check("glitch_error", 32'(ast_source_error), 32'h0);

        tick(0, 0);
        drive_to(idx + 2, KIND_ILLEGAL);
        repeat (10) tick(0, 0);
        check("illegal_position", 32'(position), 32'hFFFD);
        close_window();
        check("illegal_error", 32'(ast_source_error), 32'h1);

        repeat (3) step(1, 10);
        repeat (10) tick(0, 0);
        check("wrap_up_position", 32'(position), 32'h0000);
        step(-1, 10);
        repeat (10) tick(0, 0);
        check("wrap_down_position", 32'(position), 32'hFFFF);
        step(1, 1);
        repeat (5) tick(0, 0);
        tick(0, 1);
        tick(0, 0);
        check("clear_beats_step", 32'(position), 32'h0);
        repeat (10) tick(0, 0);

        close_window();
        repeat (5) step(1, 6);
        repeat (10) tick(0, 0);
        close_window();
        check("win5_valid", 32'(ast_source_valid), 32'd1);
        check("win5_data",  32'(ast_source_data),  32'd5);
        check("win5_error", 32'(ast_source_error), 32'h0);
        tick(0, 0);
        check("win5_valid_drop", 32'(ast_source_valid), 32'd0);
        check("win5_data_hold",  32'(ast_source_data),  32'd5);

        repeat (3000) step(1, 5);
        repeat (10) tick(0, 0);
        close_window();
        check("sat_data",  32'(ast_source_data),  32'h7FF);
        check("sat_error", 32'(ast_source_error), 32'h2);

        repeat (3) step(-1, 6);
        repeat (10) tick(0, 0);
        tick(0, 0);
        reset_n = 1'b0;
        tick(0, 0);
        check("midreset_position", 32'(position),         32'h0);
        check("midreset_data",     32'(ast_source_data),  32'h0);
        check("midreset_valid",    32'(ast_source_valid), 32'h0);
        tick(0, 0);
        reset_n = 1'b1;
        close_window();
        check("unprimed_valid", 32'(ast_source_valid), 32'd1);
        check("unprimed_data",  32'(ast_source_data),  32'h0);
        check("unprimed_error", 32'(ast_source_error), 32'h0);
        repeat (12) tick(0, 0);

        rnd = 1'b1;
        repeat (400) begin
            r = $urandom_range(0, 9);
            if (r < 4)       step(1, $urandom_range(5, 9));
            else if (r < 7)  step(-1, $urandom_range(5, 9));
            else if (r < 9)  glitch($urandom_range(0, 1) == 1, $urandom_range(1, 3));
            else begin
                tick(0, 0);
                drive_to(idx + 2, KIND_ILLEGAL);
                repeat (6) tick(0, 0);
            end
        end
        rnd = 1'b0;
        repeat (12) tick(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
